// File: rtl/multiport_register_file_pkg.sv
// Shared types and the write-port match helper for the multiport register file.
// The write path, the bypass path and the scoreboard all resolve writes through wr_match.
package multiport_register_file_pkg;

    localparam int unsigned MaxPorts = 4;
    localparam int unsigned MaxAw    = 16;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } wmatch_t;

    // Highest-indexed enabled port whose select equals target; selects are zero-padded to MaxAw.
    function automatic wmatch_t wr_match(input logic [MaxPorts-1:0]       wen,
                                         input logic [MaxPorts*MaxAw-1:0] wsel,
                                         input logic [MaxAw-1:0]          target);
        wmatch_t m;
        m = '0;
        for (int p = 0; p < MaxPorts; p++) begin
            if (wen[p] && (wsel[p*MaxAw +: MaxAw] == target)) begin
                m.hit = 1'b1;
                m.idx = 2'(p);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// Decode/writeback-facing bus of the multiport register file.
// The master side is decode plus writeback; the slave side is the register file.
interface multiport_register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 2
) ();
    localparam int unsigned AW = $clog2(NREGS);

    logic [NWRITE-1:0]        wen;
    logic [NWRITE*AW-1:0]     wsel;
    logic [NWRITE*DATA_W-1:0] wdat;
    logic [NREAD*AW-1:0]      rsel;
    logic [NREAD*DATA_W-1:0]  rdat;
    logic [NREAD-1:0]         rbusy;
    logic                     alloc_en;
    logic [AW-1:0]            alloc_sel;
    logic [NREGS-1:0]         busy_vec;
    logic                     wcollide;

    modport master (
        output wen, wsel, wdat, rsel, alloc_en, alloc_sel,
        input  rdat, rbusy, busy_vec, wcollide
    );

    modport slave (
        input  wen, wsel, wdat, rsel, alloc_en, alloc_sel,
        output rdat, rbusy, busy_vec, wcollide
    );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: writeback clears, allocation sets (allocation wins).
// rbusy reflects this cycle's writeback clears but not this cycle's allocation.
module rf_scoreboard
    import multiport_register_file_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [MaxPorts-1:0]       i_wen,
    input  logic [MaxPorts*MaxAw-1:0] i_wsel,
    input  logic                      i_alloc_en,
    input  logic [AW-1:0]             i_alloc_sel,
    input  logic [NREAD*AW-1:0]       i_rsel,
    output logic [NREAD-1:0]          o_rbusy,
    output logic [NREGS-1:0]          o_busy_vec
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_clr;
    logic [NREGS-1:0] w_busy_after;
    logic [NREGS-1:0] w_busy_set;

    always_comb begin
        w_busy_clr = '0;
        w_busy_set = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_clr[i] = wr_match(i_wen, i_wsel, MaxAw'(i)).hit;
            w_busy_set[i] = i_alloc_en && (i_alloc_sel == AW'(i))
                            && !((ZERO_REG != 0) && (i == 0));
        end
        w_busy_after = r_busy & ~w_busy_clr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_after | w_busy_set;
        end
    end

    always_comb begin
        o_rbusy = '0;
        for (int r = 0; r < NREAD; r++) begin
            o_rbusy[r] = w_busy_after[i_rsel[r*AW +: AW]];
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/multiport_register_file.sv
// Multi-read, multi-write register file with optional same-cycle bypass and a busy scoreboard.
// Writes to the same register resolve highest-port-wins; such conflicts pulse wcollide next cycle.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NWRITE   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    multiport_register_file_if.slave      bus
);
    logic [DATA_W-1:0]         r_mem [NREGS];
    logic                      r_wcollide;

    logic [MaxPorts-1:0]       w_wen;
    logic [MaxPorts*MaxAw-1:0] w_wsel;
    logic [DATA_W-1:0]         w_wdat [MaxPorts];
    wmatch_t                   w_wm   [NREGS];
    logic [AW-1:0]             w_rsel [NREAD];
    wmatch_t                   w_rm   [NREAD];
    logic                      w_collide;

    // Writes to a hardwired zero register are dropped here, so nothing downstream ever sees them.
    always_comb begin
        w_wen  = '0;
        w_wsel = '0;
        for (int p = 0; p < MaxPorts; p++) begin
            w_wdat[p] = '0;
        end
        for (int p = 0; p < NWRITE; p++) begin
            w_wen[p]                    = bus.wen[p]
                                          && !((ZERO_REG != 0) && (bus.wsel[p*AW +: AW] == '0));
            w_wsel[p*MaxAw +: MaxAw]    = MaxAw'(bus.wsel[p*AW +: AW]);
            w_wdat[p]                   = bus.wdat[p*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_wm[i] = wr_match(w_wen, w_wsel, MaxAw'(i));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_wm[i].hit) begin
                    r_mem[i] <= w_wdat[w_wm[i].idx];
                end
            end
        end
    end

    always_comb begin
        w_collide = 1'b0;
        for (int p = 0; p < MaxPorts; p++) begin
            for (int q = p + 1; q < MaxPorts; q++) begin
                if (w_wen[p] && w_wen[q]
                    && (w_wsel[p*MaxAw +: MaxAw] == w_wsel[q*MaxAw +: MaxAw])) begin
                    w_collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wcollide <= 1'b0;
        end else begin
            r_wcollide <= w_collide;
        end
    end

    // Register 0 under ZERO_REG is never written nor matched, so it naturally reads 0.
    always_comb begin
        bus.rdat = '0;
        for (int r = 0; r < NREAD; r++) begin
            w_rsel[r] = bus.rsel[r*AW +: AW];
            w_rm[r]   = wr_match(w_wen, w_wsel, MaxAw'(w_rsel[r]));
            if ((BYPASS != 0) && w_rm[r].hit) begin
                bus.rdat[r*DATA_W +: DATA_W] = w_wdat[w_rm[r].idx];
            end else begin
                bus.rdat[r*DATA_W +: DATA_W] = r_mem[w_rsel[r]];
            end
        end
    end

    assign bus.wcollide = r_wcollide;

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .i_clk       (CLK),
        .i_rst_n     (nRST),
        .i_wen       (w_wen),
        .i_wsel      (w_wsel),
        .i_alloc_en  (bus.alloc_en),
        .i_alloc_sel (bus.alloc_sel),
        .i_rsel      (bus.rsel),
        .o_rbusy     (bus.rbusy),
        .o_busy_vec  (bus.busy_vec)
    );

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised successor to the single-write, dual-read register file, for a dual-issue pipeline.
- Configurable data width, register count, number of read ports and number of write ports.
- Same-cycle write-to-read bypass can be enabled or disabled.
- Per-register busy scoreboard: set when a producer is allocated, cleared when that register is written back, so decode can detect RAW hazards.
- Sits between decode (read and allocate) and writeback (write).

Parameters:
DATA_W, 32, data word width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
AW, $clog2(NREGS), register select width (derived; never overridden)
NREAD, 2, number of read ports (1..4)
NWRITE, 2, number of write ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 hardwired to zero

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, asynchronous, active-low
wen  input  NWRITE  per-port write enable
wsel  input  NWRITE*AW  per-port write register index, port p at [p*AW +: AW]
wdat  input  NWRITE*DATA_W  per-port write data
rsel  input  NREAD*AW  per-port read register index
rdat  output  NREAD*DATA_W  per-port read data (combinational)
rbusy  output  NREAD  per-port: selected register still busy after this cycle's writes
alloc_en  input  1  mark alloc_sel busy (producer dispatched)
alloc_sel  input  AW  register to mark busy
busy_vec  output  NREGS  registered busy bit per register
wcollide  output  1  registered pulse: two or more enabled write ports targeted the same register in the previous cycle

Behaviour:
- Reset (nRST low, asynchronous):
  - all registers clear to 0, busy_vec = 0, wcollide = 0.
  - Takes effect immediately, including mid-write; the first rising edge after release is a normal cycle.
- Write (rising edge): every port p with wen[p]=1 updates register wsel[p] with wdat[p].
- Same-register write conflict: the highest-indexed enabled port wins; wcollide = 1 in the next cycle only.
- ZERO_REG=1:
  - writes to register 0 are discarded and do not count as collisions;
  - register 0 always reads 0, is never bypassed, and is never busy (alloc to 0 ignored);
  - rbusy for register 0 is always 0.
- Read is combinational (zero latency).
  - With BYPASS=1, if any enabled write port targets rsel[r], rdat[r] = that port's wdat, using the same highest-index-wins rule as the write.
  - Otherwise rdat[r] = stored value.
- Scoreboard, next-state per register i, evaluated in this order:
  - any enabled write to i clears busy;
  - alloc_en with alloc_sel == i sets busy.
  - So allocating and writing the same register in one cycle leaves it busy: the new producer wins.
- rbusy[r] = busy_vec[rsel[r]] after clearing by this cycle's writes.
  - Not affected by this cycle's alloc.
  - A read whose producer writes back this cycle sees rbusy = 0 and, with BYPASS=1, the forwarded data.
  - With BYPASS=0, rbusy is still cleared by the write, but rdat holds the old value until the next cycle.
- A write to a register that is not busy is legal; busy stays 0.
- Out-of-range indices cannot occur because NREGS is a power of two.

Decomposition:
- cpu_types_pkg supplies word_t and regbits_t for the default configuration.
- Add a parametrised helper function to the package: highest-index-match select over write ports, shared by the write path and the bypass path.
- One sub-module: rf_scoreboard (busy_vec register, set/clear logic, rbusy lookup).
- Storage, write arbitration, bypass and wcollide stay in the top module.

Test Plan:
1. Reset, then read all 32 registers on both read ports -> rdat = 0, busy_vec = 0, wcollide = 0.
2. Port0 writes reg5 = 0xDEADBEEF while read port 0 selects reg5 -> BYPASS=1: rdat0 = 0xDEADBEEF in the same cycle; BYPASS=0: old value, then 0xDEADBEEF next cycle.
3. Port0 writes reg7 = 0x11 and port1 writes reg7 = 0x22 in the same cycle -> reg7 = 0x22; wcollide = 1 for exactly one cycle; rdat bypass = 0x22.
4. Alloc reg9 -> busy_vec[9] = 1 and rbusy = 1 when reading reg9; write reg9 = 0x55 -> rbusy = 0 in the write cycle, busy_vec[9] = 0 next cycle.
5. Alloc reg3 and write reg3 = 0x1 in the same cycle -> busy_vec[3] = 1 afterwards; reg3 = 0x1.
6. Write reg0 = 0xFFFFFFFF on both ports and alloc reg0, then assert nRST low mid-cycle -> reg0 reads 0, busy_vec[0] = 0, no wcollide; asynchronous reset clears everything immediately.
